// File: rtl/snake_pkg.sv
// Shared constants, types and helpers for the snake game sequencer.
package snake_pkg;

  localparam int H_DISP      = 800;
  localparam int V_DISP      = 600;
  localparam int BLOCK_W     = 10;
  localparam int MAX_LEN     = 32;
  localparam int INIT_LEN    = 3;
  localparam int MOVE_FRAMES = 8;

  localparam int XW = 7;
  localparam int YW = 6;

  typedef logic [XW-1:0] cx_t;
  typedef logic [YW-1:0] cy_t;

  localparam cx_t GRID_W = 7'd80;
  localparam cy_t GRID_H = 6'd60;

  localparam cx_t INIT_X = 7'd40;
  localparam cy_t INIT_Y = 6'd30;
  localparam cx_t FOOD_X = 7'd60;
  localparam cy_t FOOD_Y = 6'd30;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [2:0] {IDLE, RUN, CALC, CHECK, SHIFT, FOOD, OVER} state_t;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a == UP && b == DOWN) || (a == DOWN && b == UP) ||
           (a == LEFT && b == RIGHT) || (a == RIGHT && b == LEFT);
  endfunction

  function automatic logic in_cell(input logic [10:0] p, input logic [10:0] base);
    return (p >= base) && (p < base + 11'(BLOCK_W));
  endfunction

endpackage

// File: rtl/snake_food_gen.sv
// Free-running LFSR; offers an in-grid food candidate whenever req is high.
module snake_food_gen
  import snake_pkg::*;
(
  input  logic vga_clk,
  input  logic sys_rst_n,
  input  logic req,
  output logic valid,
  output cx_t  food_x,
  output cy_t  food_y
);

  logic [15:0] lfsr;
  logic        fb;

  // Fibonacci taps 16,14,13,11
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lfsr <= LFSR_SEED;
    else            lfsr <= {lfsr[14:0], fb};
  end

  assign food_x = lfsr[6:0];
  assign food_y = lfsr[13:8];
  assign valid  = req && (food_x < GRID_W) && (food_y < GRID_H);

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE, RUN, CALC, CHECK, SHIFT, FOOD, OVER.
// Define WALL_WRAP_EN to wrap the head around the grid instead of ending on a wall.
module snake_game_ctrl
  import snake_pkg::*;
(
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        start,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic        snack_r,
  output logic        fin,
  output logic [7:0]  score
);

  localparam int LW  = $clog2(MAX_LEN + 1);
  localparam int IW  = $clog2(MAX_LEN);
  localparam int FCW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

  state_t          state;
  dir_t            dir, pend, key_dir;
  logic            key_hit, key_ok;
  logic [LW-1:0]   len;
  logic [IW-1:0]   idx, lim_m1;
  logic [FCW-1:0]  frame_cnt;
  cx_t             seg_x [MAX_LEN];
  cy_t             seg_y [MAX_LEN];
  cx_t             food_x, nh_x, cand_x, gen_x;
  cy_t             food_y, nh_y, cand_y, gen_y;
  logic            eat, eat_c, wall, gen_valid, frame_tick, match;
  logic signed [7:0] sx;
  logic signed [6:0] sy;

  snake_food_gen u_food (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .req       (state == FOOD),
    .valid     (gen_valid),
    .food_x    (gen_x),
    .food_y    (gen_y)
  );

  assign frame_tick = (pixel_xpos == 11'(H_DISP - 1)) && (pixel_ypos == 11'(V_DISP - 1));

  always_comb begin
    key_hit = 1'b1;
    key_dir = RIGHT;
    if      (key_up)    key_dir = UP;
    else if (key_down)  key_dir = DOWN;
    else if (key_left)  key_dir = LEFT;
    else if (key_right) key_dir = RIGHT;
    else                key_hit = 1'b0;
  end

  // Rejecting reversal of the pending dir too stops two quick keys doing a U-turn.
  assign key_ok = key_hit && !is_reverse(key_dir, dir) && !is_reverse(key_dir, pend);

  always_comb begin
    sx = signed'({1'b0, seg_x[0]});
    sy = signed'({1'b0, seg_y[0]});
    case (pend)
      UP:      sy = sy - 7'sd1;
      DOWN:    sy = sy + 7'sd1;
      LEFT:    sx = sx - 8'sd1;
      default: sx = sx + 8'sd1;
    endcase
`ifdef WALL_WRAP_EN
    wall = 1'b0;
    if      (sx < 8'sd0)                    cand_x = GRID_W - 7'd1;
    else if (sx >= $signed({1'b0, GRID_W})) cand_x = '0;
    else                                    cand_x = sx[XW-1:0];
    if      (sy < 7'sd0)                    cand_y = GRID_H - 6'd1;
    else if (sy >= $signed({1'b0, GRID_H})) cand_y = '0;
    else                                    cand_y = sy[YW-1:0];
`else
    wall   = (sx < 8'sd0) || (sx >= $signed({1'b0, GRID_W})) ||
             (sy < 7'sd0) || (sy >= $signed({1'b0, GRID_H}));
    cand_x = sx[XW-1:0];
    cand_y = sy[YW-1:0];
`endif
    eat_c = (cand_x == food_x) && (cand_y == food_y);
  end

  assign match = (seg_x[idx] == nh_x) && (seg_y[idx] == nh_y);

  always_comb begin
    snack_r = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len) &&
          in_cell(pixel_xpos, 11'(seg_x[i]) * 11'(BLOCK_W)) &&
          in_cell(pixel_ypos, 11'(seg_y[i]) * 11'(BLOCK_W)))
        snack_r = 1'b1;
    end
  end

  assign box_x = 10'(food_x) * 10'(BLOCK_W);
  assign box_y = 10'(food_y) * 10'(BLOCK_W);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      dir       <= RIGHT;
      pend      <= RIGHT;
      len       <= LW'(INIT_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= INIT_X - cx_t'(i);
        seg_y[i] <= INIT_Y;
      end
      food_x    <= FOOD_X;
      food_y    <= FOOD_Y;
      fin       <= 1'b0;
      score     <= '0;
      frame_cnt <= '0;
      idx       <= '0;
      lim_m1    <= '0;
      nh_x      <= '0;
      nh_y      <= '0;
      eat       <= 1'b0;
    end else begin
      if (key_ok && state != OVER) pend <= key_dir;
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (frame_tick) begin
            if (frame_cnt == FCW'(MOVE_FRAMES - 1)) begin
              frame_cnt <= '0;
              state     <= CALC;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        CALC: begin
          dir  <= pend;
          nh_x <= cand_x;
          nh_y <= cand_y;
          eat  <= eat_c;
          idx  <= '0;
          // the tail vacates this step unless the snake grows
          lim_m1 <= eat_c ? IW'(len - LW'(1)) : IW'(len - LW'(2));
          if (wall) begin
            fin   <= 1'b1;
            state <= OVER;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (match) begin
            fin   <= 1'b1;
            state <= OVER;
          end else if (idx == lim_m1) begin
            state <= SHIFT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SHIFT: begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nh_x;
          seg_y[0] <= nh_y;
          if (eat) begin
            if (len != LW'(MAX_LEN)) len <= len + 1'b1;
            if (score != 8'hFF) score <= score + 1'b1;
            state <= FOOD;
          end else begin
            state <= RUN;
          end
        end
        FOOD: begin
          if (gen_valid) begin
            food_x <= gen_x;
            food_y <= gen_y;
            state  <= RUN;
          end
        end
        OVER: begin
          if (start) begin
            state     <= RUN;
            dir       <= RIGHT;
            pend      <= RIGHT;
            len       <= LW'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
              seg_x[i] <= INIT_X - cx_t'(i);
              seg_y[i] <= INIT_Y;
            end
            food_x    <= FOOD_X;
            food_y    <= FOOD_Y;
            fin       <= 1'b0;
            score     <= '0;
            frame_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl; body position is observed through snack_r probes.
module tb_snake_game_ctrl;

  localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

  logic        vga_clk, sys_rst_n;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        key_up, key_down, key_left, key_right, start;
  logic [9:0]  box_x, box_y;
  logic        snack_r, fin;
  logic [7:0]  score;

  int checks = 0;
  int errors = 0;
  int hx, hy, hd, fx, fy, hd0, p;

  snake_game_ctrl dut (
    .vga_clk    (vga_clk),
    .sys_rst_n  (sys_rst_n),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .start      (start),
    .box_x      (box_x),
    .box_y      (box_y),
    .snack_r    (snack_r),
    .fin        (fin),
    .score      (score)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic exp);
    @(negedge vga_clk);
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    #1;
    check(tag, 32'(snack_r), 32'(exp));
  endtask

  task automatic tick();
    pixel_xpos = 11'd799;
    pixel_ypos = 11'd599;
    step(1);
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd0;
  endtask

  task automatic mv_raw();
    repeat (8) begin
      tick();
      step(2);
    end
    step(80);
  endtask

  task automatic mv();
    mv_raw();
    case (hd)
      D_UP:    hy--;
      D_DOWN:  hy++;
      D_LEFT:  hx--;
      default: hx++;
    endcase
  endtask

  task automatic pulse_key(input int d);
    key_up    = (d == D_UP);
    key_down  = (d == D_DOWN);
    key_left  = (d == D_LEFT);
    key_right = (d == D_RIGHT);
    step(1);
    {key_up, key_down, key_left, key_right} = 4'b0;
  endtask

  task automatic turn(input int d);
    pulse_key(d);
    hd = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(1);
  endtask

  function automatic int opp(input int d);
    case (d)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    pixel_xpos = 11'd400;
    pixel_ypos = 11'd300;
    {key_up, key_down, key_left, key_right, start} = 5'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(1);

    // reset state and idle
    check("rst_box_x", 32'(box_x), 600);
    check("rst_box_y", 32'(box_y), 300);
    check("rst_fin", 32'(fin), 0);
    check("rst_score", 32'(score), 0);
    probe("rst_head", 405, 305, 1'b1);
    probe("rst_right_of_head", 425, 305, 1'b0);
    probe("rst_tail_edge", 380, 300, 1'b1);
    probe("rst_left_of_tail", 379, 300, 1'b0);
    probe("rst_head_corner", 409, 309, 1'b1);
    probe("rst_head_xedge", 410, 300, 1'b0);
    probe("rst_head_yedge", 405, 310, 1'b0);
    repeat (20) begin
      tick();
      step(2);
    end
    probe("idle_head", 405, 305, 1'b1);
    probe("idle_no_move", 410, 300, 1'b0);

    // basic move
    pulse_start();
    hx = 40; hy = 30; hd = D_RIGHT;
    mv();
    probe("move_head", 415, 305, 1'b1);
    probe("move_old_tail", 385, 300, 1'b0);
    probe("move_tail", 395, 300, 1'b1);
    check("move_fin", 32'(fin), 0);

    // reversal key while moving right
    pulse_key(D_LEFT);
    mv();
    probe("left_ignored_head", 425, 305, 1'b1);
    probe("left_ignored_tail", 395, 300, 1'b0);

    // down then up in one period: up is a reversal of the pending turn
    pulse_key(D_DOWN);
    step(3);
    pulse_key(D_UP);
    hd = D_DOWN;
    mv();
    probe("turn_head", 425, 315, 1'b1);
    probe("turn_not_up", 425, 295, 1'b0);
    probe("turn_not_right", 435, 305, 1'b0);
    probe("turn_neck", 425, 305, 1'b1);
    probe("turn_tail", 415, 305, 1'b1);
    probe("turn_old_tail", 405, 305, 1'b0);

    // eat the initial food at (60,30)
    do_reset();
    pulse_start();
    hx = 40; hy = 30; hd = D_RIGHT;
    repeat (19) mv();
    check("pre_eat_score", 32'(score), 0);
    check("pre_eat_box_x", 32'(box_x), 600);
    mv();
    check("eat_score", 32'(score), 1);
    check("eat_fin", 32'(fin), 0);
    probe("eat_head", 605, 305, 1'b1);
    probe("eat_len4_tail", 575, 305, 1'b1);
    probe("eat_len4_beyond", 565, 305, 1'b0);
    check("food_x_mult", 32'(box_x % 10), 0);
    check("food_y_mult", 32'(box_y % 10), 0);
    check("food_x_range", 32'(box_x / 10 < 80), 1);
    check("food_y_range", 32'(box_y / 10 < 60), 1);

    // steer onto the spawned food to reach length 5
    fx = int'(box_x) / 10;
    fy = int'(box_y) / 10;
    if (fy == hy && fx < hx) begin
      turn(D_UP); mv(); mv();
      turn(D_LEFT);
      while (hx > fx) mv();
      turn(D_DOWN); mv(); mv();
    end else begin
      if (fy < hy) begin
        turn(D_UP);
        while (hy > fy) mv();
      end else if (fy > hy) begin
        turn(D_DOWN);
        while (hy < fy) mv();
      end
      if (fx > hx) begin
        turn(D_RIGHT);
        while (hx < fx) mv();
      end else if (fx < hx) begin
        turn(D_LEFT);
        while (hx > fx) mv();
      end
    end
    check("eat2_score", 32'(score), 2);
    check("eat2_fin", 32'(fin), 0);

    // tight U-turn into the neck segment: collides at length 5
    hd0 = hd;
    fx = hx; fy = hy;
    if (hd0 == D_LEFT || hd0 == D_RIGHT) p = (hy < 59) ? D_DOWN : D_UP;
    else                                 p = (hx < 79) ? D_RIGHT : D_LEFT;
    turn(p); mv();
    turn(opp(hd0)); mv();
    turn(opp(p)); mv_raw();
    check("self_hit_fin", 32'(fin), 1);
    mv_raw();
    check("over_fin_held", 32'(fin), 1);
    check("over_score_held", 32'(score), 2);
    probe("over_body_frozen", fx * 10 + 5, fy * 10 + 5, 1'b1);

    // restart from OVER
    pulse_start();
    check("restart_fin", 32'(fin), 0);
    check("restart_score", 32'(score), 0);
    check("restart_box_x", 32'(box_x), 600);
    check("restart_box_y", 32'(box_y), 300);
    probe("restart_head", 405, 305, 1'b1);
    probe("restart_tail", 385, 305, 1'b1);
    probe("restart_len3", 375, 305, 1'b0);

    // run along row 29 into the right wall
    hx = 40; hy = 30; hd = D_RIGHT;
    turn(D_UP); mv();
    turn(D_RIGHT);
    repeat (39) mv();
    check("edge_fin", 32'(fin), 0);
    probe("edge_head", 795, 295, 1'b1);
    mv_raw();
`ifdef WALL_WRAP_EN
    check("wrap_fin", 32'(fin), 0);
    probe("wrap_head", 5, 295, 1'b1);
    probe("wrap_neck", 795, 295, 1'b1);
`else
    check("wall_fin", 32'(fin), 1);
    check("wall_score", 32'(score), 0);
    probe("wall_frozen", 795, 295, 1'b1);
`endif

    // async reset in the middle of CHECK
    pulse_start();
    pulse_key(D_UP);
    mv_raw();
    repeat (7) begin
      tick();
      step(2);
    end
    tick();
    step(1);
    sys_rst_n = 1'b0;
    #1;
    check("arst_fin", 32'(fin), 0);
    check("arst_score", 32'(score), 0);
    check("arst_box_x", 32'(box_x), 600);
    check("arst_box_y", 32'(box_y), 300);
    probe("arst_head", 405, 305, 1'b1);
    probe("arst_tail", 385, 305, 1'b1);
    probe("arst_no_up", 405, 295, 1'b0);
    probe("arst_no_wrap", 5, 285, 1'b0);
    step(2);
    sys_rst_n = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
